// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle: both producer handshakes, the register-file
// write port, the hazard query pair and the FIFO occupancy.
interface wb_arbiter_if #(
   parameter int DEPTH = 2
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          a_valid;
   logic          a_ready;
   logic [4:0]    a_rd;
   logic [31:0]   a_data;

   logic          b_valid;
   logic          b_ready;
   logic [4:0]    b_rd;
   logic [31:0]   b_data;

   logic          wb_we;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;

   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic          busy1;
   logic          busy2;

   logic [CW-1:0] b_count;

   // Arbiter side
   modport slave (
      input  a_valid, a_rd, a_data,
      input  b_valid, b_rd, b_data,
      input  rs1, rs2,
      output a_ready, b_ready,
      output wb_we, wb_rd, wb_data,
      output busy1, busy2, b_count
   );

   // Producer / regfile / issue side
   modport master (
      output a_valid, a_rd, a_data,
      output b_valid, b_rd, b_data,
      output rs1, rs2,
      input  a_ready, b_ready,
      input  wb_we, wb_rd, wb_data,
      input  busy1, busy2, b_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single regfile write port.
// Source A (high priority, unbuffered) wins the port unless the starvation
// counter says B has waited STARVE_LIMIT A-wins; source B is queued in a
// small FIFO. busy1/busy2 flag pending writes to rs1/rs2 from the FIFO or
// from the registered write-back stage.
module wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

   logic [4:0]    rd_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;

   logic          wb_we_q, wb_we_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [31:0]   wb_data_q, wb_data_d;

   logic          empty, full, force_b;
   logic          push, pop, a_win;
   logic          busy1_hit, busy2_hit;

   // Handshake and port selection
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == FULL_CNT);
      force_b = (starve_q == LIMIT) && !empty;
      a_win   = bus.a_valid && !force_b;
      push    = bus.b_valid && !full;
      pop     = !a_win && !empty;
   end

   // Next-state for occupancy, starvation counter and write-back stage
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      starve_d = '0;
      if (a_win && !empty) begin
         starve_d = (starve_q == LIMIT) ? starve_q : starve_q + SW'(1);
      end

      // Idle cycles keep the last rd/data; only the strobe drops.
      wb_we_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (a_win) begin
         wb_we_d   = (bus.a_rd != 5'd0);
         wb_rd_d   = bus.a_rd;
         wb_data_d = bus.a_data;
      end else if (pop) begin
         wb_we_d   = (rd_mem_q[rd_ptr_q] != 5'd0);
         wb_rd_d   = rd_mem_q[rd_ptr_q];
         wb_data_d = data_mem_q[rd_ptr_q];
      end
   end

   // FIFO storage and pointers; push and pop never hit the same slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            rd_mem_q[wr_ptr_q]   <= bus.b_rd;
            data_mem_q[wr_ptr_q] <= bus.b_data;
            vld_q[wr_ptr_q]      <= 1'b1;
            wr_ptr_q             <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Occupancy, starvation and registered write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         starve_q  <= '0;
         wb_we_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         count_q   <= count_d;
         starve_q  <= starve_d;
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // Hazard scoreboard: queued B writes plus the write currently on the port
   always_comb begin
      busy1_hit = wb_we_q && (wb_rd_q == bus.rs1);
      busy2_hit = wb_we_q && (wb_rd_q == bus.rs2);
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (rd_mem_q[i] == bus.rs1)) busy1_hit = 1'b1;
         if (vld_q[i] && (rd_mem_q[i] == bus.rs2)) busy2_hit = 1'b1;
      end
   end

   assign bus.a_ready = !force_b;
   assign bus.b_ready = !full;
   assign bus.b_count = count_q;
   assign bus.wb_we   = wb_we_q;
   assign bus.wb_rd   = wb_rd_q;
   assign bus.wb_data = wb_data_q;
   assign bus.busy1   = busy1_hit && (bus.rs1 != 5'd0);
   assign bus.busy2   = busy2_hit && (bus.rs2 != 5'd0);
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle vector table with expected handshake,
// occupancy and hazard flags; expected write-back results are queued when a
// row is driven and compared one cycle later. Async reset handled by hand.
module tb_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] ad;
      logic        bv;  logic [4:0] brd; logic [31:0] bd;
      logic [4:0]  rs1; logic [4:0] rs2;
      logic        e_ar; logic e_br; logic [1:0] e_cnt; logic e_b1; logic e_b2;
      logic        n_we; logic [4:0] n_rd; logic [31:0] n_data;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   localparam int NV = 25;
   vec_t vecs [NV];
   wb_t  sbq [$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(int av, int ard, int ad, int bv, int brd, int bd,
                               int rs1, int rs2, int ear, int ebr, int ecnt,
                               int eb1, int eb2, int nwe, int nrd, int nd);
      vec_t v;
      v.av = av[0];   v.ard = ard[4:0]; v.ad = ad;
      v.bv = bv[0];   v.brd = brd[4:0]; v.bd = bd;
      v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0];
      v.e_ar = ear[0]; v.e_br = ebr[0]; v.e_cnt = ecnt[1:0];
      v.e_b1 = eb1[0]; v.e_b2 = eb2[0];
      v.n_we = nwe[0]; v.n_rd = nrd[4:0]; v.n_data = nd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.a_valid = v.av;  bus.a_rd = v.ard; bus.a_data = v.ad;
      bus.b_valid = v.bv;  bus.b_rd = v.brd; bus.b_data = v.bd;
      bus.rs1 = v.rs1;     bus.rs2 = v.rs2;
   endtask

   task automatic check_wb(input string tag);
      wb_t e;
      if (sbq.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
         return;
      end
      e = sbq.pop_front();
      chk({tag, " wb_we"}, {31'd0, bus.wb_we}, {31'd0, e.we});
      if (e.we) begin
         chk({tag, " wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, e.rd});
         chk({tag, " wb_data"}, bus.wb_data, e.data);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " wb_we"},   {31'd0, bus.wb_we},   32'd0);
      chk({tag, " wb_rd"},   {27'd0, bus.wb_rd},   32'd0);
      chk({tag, " wb_data"}, bus.wb_data,          32'd0);
      chk({tag, " b_count"}, {30'd0, bus.b_count}, 32'd0);
      chk({tag, " busy1"},   {31'd0, bus.busy1},   32'd0);
      chk({tag, " busy2"},   {31'd0, bus.busy2},   32'd0);
      chk({tag, " a_ready"}, {31'd0, bus.a_ready}, 32'd1);
      chk({tag, " b_ready"}, {31'd0, bus.b_ready}, 32'd1);
   endtask

   initial begin
      vec_t idle;
      string tag;

      //               av ard ad            bv brd bd           rs1 rs2 ar br cnt b1 b2  nwe nrd nd
      vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            5,  3,  1, 1, 0, 0, 0,  1, 5,  32'hDEADBEEF);
      vecs[1]  = mk(0, 0, 0,            0, 0, 0,            5,  3,  1, 1, 0, 1, 0,  0, 0,  0);
      vecs[2]  = mk(0, 0, 0,            1, 7, 32'h12345678, 7,  7,  1, 1, 0, 0, 0,  0, 0,  0);
      vecs[3]  = mk(0, 0, 0,            0, 0, 0,            7,  7,  1, 1, 1, 1, 1,  1, 7,  32'h12345678);
      vecs[4]  = mk(0, 0, 0,            0, 0, 0,            7,  7,  1, 1, 0, 1, 1,  0, 0,  0);
      vecs[5]  = mk(0, 0, 0,            0, 0, 0,            7,  7,  1, 1, 0, 0, 0,  0, 0,  0);
      vecs[6]  = mk(1, 1, 32'hA1,       1, 9, 32'hB9,       9,  1,  1, 1, 0, 0, 0,  1, 1,  32'hA1);
      vecs[7]  = mk(1, 2, 32'hA2,       0, 0, 0,            9,  1,  1, 1, 1, 1, 1,  1, 2,  32'hA2);
      vecs[8]  = mk(1, 3, 32'hA3,       0, 0, 0,            9,  2,  1, 1, 1, 1, 1,  1, 3,  32'hA3);
      vecs[9]  = mk(1, 4, 32'hA4,       0, 0, 0,            9,  1,  1, 1, 1, 1, 0,  1, 4,  32'hA4);
      vecs[10] = mk(1, 5, 32'hA5,       0, 0, 0,            9,  4,  1, 1, 1, 1, 1,  1, 5,  32'hA5);
      vecs[11] = mk(1, 6, 32'hA6,       0, 0, 0,            9,  5,  0, 1, 1, 1, 1,  1, 9,  32'hB9);
      vecs[12] = mk(1, 6, 32'hA6,       0, 0, 0,            9,  6,  1, 1, 0, 1, 0,  1, 6,  32'hA6);
      vecs[13] = mk(1, 10, 32'h10,      1, 11, 32'hB11,     11, 6,  1, 1, 0, 0, 1,  1, 10, 32'h10);
      vecs[14] = mk(1, 12, 32'h12,      1, 13, 32'hB13,     13, 11, 1, 1, 1, 0, 1,  1, 12, 32'h12);
      vecs[15] = mk(1, 14, 32'h14,      1, 15, 32'hB15,     13, 12, 1, 0, 2, 1, 1,  1, 14, 32'h14);
      vecs[16] = mk(1, 16, 32'h16,      1, 15, 32'hB15,     15, 14, 1, 0, 2, 0, 1,  1, 16, 32'h16);
      vecs[17] = mk(1, 17, 32'h17,      1, 15, 32'hB15,     11, 15, 1, 0, 2, 1, 0,  1, 17, 32'h17);
      vecs[18] = mk(1, 18, 32'h18,      1, 15, 32'hB15,     11, 17, 0, 0, 2, 1, 1,  1, 11, 32'hB11);
      vecs[19] = mk(1, 18, 32'h18,      1, 15, 32'hB15,     11, 13, 1, 1, 1, 1, 1,  1, 18, 32'h18);
      vecs[20] = mk(0, 0, 0,            0, 0, 0,            15, 18, 1, 0, 2, 1, 1,  1, 13, 32'hB13);
      vecs[21] = mk(0, 0, 0,            0, 0, 0,            15, 13, 1, 1, 1, 1, 1,  1, 15, 32'hB15);
      vecs[22] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hB0,       0,  15, 1, 1, 0, 0, 1,  0, 0,  0);
      vecs[23] = mk(0, 0, 0,            0, 0, 0,            0,  0,  1, 1, 1, 0, 0,  0, 0,  0);
      vecs[24] = mk(0, 0, 0,            0, 0, 0,            0,  0,  1, 1, 0, 0, 0,  0, 0,  0);
      idle     = mk(0, 0, 0,            0, 0, 0,            0,  0,  1, 1, 0, 0, 0,  0, 0,  0);

      rst = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 check_reset_vals("reset");

      sbq.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0});
      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1 drive(vecs[i]);
         #4;
         tag = $sformatf("row%0d", i);
         chk({tag, " a_ready"}, {31'd0, bus.a_ready}, {31'd0, vecs[i].e_ar});
         chk({tag, " b_ready"}, {31'd0, bus.b_ready}, {31'd0, vecs[i].e_br});
         chk({tag, " b_count"}, {30'd0, bus.b_count}, {30'd0, vecs[i].e_cnt});
         chk({tag, " busy1"},   {31'd0, bus.busy1},   {31'd0, vecs[i].e_b1});
         chk({tag, " busy2"},   {31'd0, bus.busy2},   {31'd0, vecs[i].e_b2});
         check_wb(tag);
         sbq.push_back('{we: vecs[i].n_we, rd: vecs[i].n_rd, data: vecs[i].n_data});
      end
      @(posedge clk);
      #1 drive(idle);
      #4 check_wb("drain");

      // Async reset with two queued B entries and a live write on the port
      @(posedge clk);
      #1 drive(mk(1, 20, 32'h20, 1, 21, 32'hB21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 drive(mk(1, 22, 32'h22, 1, 23, 32'hB23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 drive(mk(0, 0, 0, 0, 0, 0, 21, 22, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("pre-rst b_count", {30'd0, bus.b_count}, 32'd2);
      chk("pre-rst b_ready", {31'd0, bus.b_ready}, 32'd0);
      chk("pre-rst wb_we",   {31'd0, bus.wb_we},   32'd1);
      chk("pre-rst wb_rd",   {27'd0, bus.wb_rd},   32'd22);
      chk("pre-rst busy1",   {31'd0, bus.busy1},   32'd1);
      chk("pre-rst busy2",   {31'd0, bus.busy2},   32'd1);
      #1 rst = 1'b1;
      #1 check_reset_vals("async-rst");
      @(posedge clk);
      #2 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tag = $sformatf("post-rst%0d", k);
         chk({tag, " wb_we"},   {31'd0, bus.wb_we},   32'd0);
         chk({tag, " b_count"}, {30'd0, bus.b_count}, 32'd0);
         chk({tag, " busy1"},   {31'd0, bus.busy1},   32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the register file's single write port. Two producers share the port: source A (the single-cycle ALU/load path, high priority, unbuffered) and source B (a multi-cycle unit such as a divider, low priority, buffered in a small FIFO). A starvation limit guarantees B forward progress. A combinational scoreboard reports pending writes so the issue logic can stall on read-after-write hazards. Outputs drive the register file's `reg_write`/`rd`/`write_data` directly.

## Interface
- `DEPTH`, 2, source-B FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive A wins with B waiting before A is blocked for one cycle (≥1)
- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `a_valid` in 1 — source A write request
- `a_ready` out 1 — A accepted when `a_valid && a_ready`
- `a_rd` in 5 — A destination register
- `a_data` in 32 — A write data
- `b_valid` in 1 — source B write request
- `b_ready` out 1 — B accepted into FIFO when `b_valid && b_ready`
- `b_rd` in 5 — B destination register
- `b_data` in 32 — B write data
- `wb_we` out 1 — to regfile `reg_write`, registered
- `wb_rd` out 5 — to regfile `rd`, registered
- `wb_data` out 32 — to regfile `write_data`, registered
- `rs1`, `rs2` in 5 each — hazard query addresses
- `busy1`, `busy2` out 1 each — pending write to `rs1`/`rs2`
- `b_count` out log2(DEPTH)+1 — current FIFO occupancy

## Operation
- FIFO: `b_ready = !full`. No pass-through when full, even if popped the same cycle. Push and pop in the same cycle are legal when not full; count is unchanged.
- Starvation flag `force_b = (starve_cnt == STARVE_LIMIT) && !empty`.
- `a_ready = !force_b`, combinational from state only; it never depends on `a_valid`.
- Selection each cycle:
  - If `a_valid && a_ready`, A is written.
  - Else if FIFO non-empty, the head is popped and written.
  - Else idle.
- `starve_cnt`:
  - +1 when A is written while the FIFO is non-empty (saturating at STARVE_LIMIT).
  - Cleared when a B entry is popped or the FIFO is empty.
- Selected write is registered into `wb_*` at the next edge; `wb_we` is 0 on idle cycles.
- Entries with `rd == 0` are accepted and consumed normally, but the registered `wb_we` is forced to 0. x0 is never written.
- Scoreboard: `busyN = (rsN != 0)` and (any valid FIFO entry has `rd == rsN`, or `wb_we && wb_rd == rsN`). Combinational. A requests in the current cycle are not included.
- Ordering between A and B writes to the same register is not guaranteed. Issue logic uses `busy*` to prevent overlap. Order within B is FIFO order.

## Timing
- A accepted in cycle N → `wb_we` high during N+1 → regfile updated at the end of N+1.
- B accepted in cycle N → earliest pop in N+1 → earliest `wb_we` in N+2.
- Worst-case B wait with A continuously valid: STARVE_LIMIT A writes, then one forced B write.
- Throughput: one write per cycle maximum.
- Reset (asynchronous, immediate) clears:
  - FIFO to empty, `starve_cnt` = 0.
  - `wb_we` = 0, `wb_rd` = 0, `wb_data` = 0, `b_count` = 0, `busy1` = `busy2` = 0.
  - `a_ready` = 1, `b_ready` = 1.
- Reset mid-operation discards all buffered B entries and any registered write.
- Reset release: no write in the first cycle after deassertion unless a request is accepted in that cycle.

## Test plan
- A only: `a_valid=1, a_rd=5, a_data=0xDEADBEEF` in cycle 1 → `wb_we=1, wb_rd=5, wb_data=0xDEADBEEF` in cycle 2; `b_count=0` throughout.
- B only: push `rd=7, 0x12345678` in cycle 1 → `busy1=1` for `rs1=7` from cycle 2; `wb_we=1, wb_rd=7` in cycle 3; `busy1=0` in cycle 4.
- Starvation: A valid every cycle, one B entry pushed in cycle 0, STARVE_LIMIT=4 → A written in cycles 1–4, `a_ready=0` in cycle 5, B popped in cycle 5 and on `wb_*` in cycle 6, `a_ready=1` in cycle 6.
- FIFO full: with A saturating the port, push 2 B entries → `b_ready=0`, `b_count=2`. A third `b_valid` is not accepted until the cycle after the first pop.
- x0: A writes `rd=0, 0xFFFFFFFF` → `wb_we=0` next cycle. `busy1=0` for `rs1=0` with a B `rd=0` entry queued.
- Async reset with 2 B entries queued and `wb_we=1` → all outputs at reset values immediately without a clock edge. No `wb_we` pulse after release.
